icap_reconfig_seq: RTL and testbench
====================================

Name: icap_reconfig_seq

Overview:
- Sequences the FPGA's ICAP primitive to perform a multiboot reconfiguration (IPROG) into a selected SPI flash image.
- Sits between the Tube-side design-select/reconfigure logic and the ICAP primitive.
- Accepts a one-cycle request carrying a 5-bit design number and computes that image's flash address.
- Streams the fixed 14-word Spartan-6 16-bit ICAP command sequence, then reports completion, or reports an error for an out-of-range design.

Parameters:
- BASE_ADDR, 24'h000000, flash byte address of design 0.
- DESIGN_STRIDE, 24'h060000, flash bytes per design image.
- NUM_DESIGNS, 16, valid design numbers are 0..NUM_DESIGNS-1.
- GOLDEN_ADDR, 24'h000000, fallback image address written to GENERAL3/4.
- SPI_OPCODE, 8'h0B, SPI read opcode written with the upper address bytes.
- DELAY_CYCLES, 16, fastclk cycles between request acceptance and the first ICAP word; 0 is legal.

Ports:
- fastclk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- req  in  1  one-cycle start pulse
- design_num  in  5  image select, sampled with req
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence issued
- err  out  1  one-cycle pulse, request rejected
- icap_i  out  16  ICAP data word
- icap_ce_b  out  1  ICAP chip enable, active-low
- icap_we_b  out  1  ICAP write enable, active-low (0 = write)

Behaviour:
- One clock: fastclk. Reset is asynchronous and active-low on rst_b.
- Reset values:
  - state IDLE
  - busy=0, done=0, err=0
  - icap_i=16'hFFFF, icap_ce_b=1, icap_we_b=1
  - word index 0, delay counter 0
- States: IDLE, DELAY, ISSUE, FINISH.
- IDLE:
  - On req=1: latch design_num.
  - If design_num >= NUM_DESIGNS: pulse err for one cycle the next cycle, stay IDLE, busy stays 0.
  - Otherwise: compute addr = (BASE_ADDR + design_num*DESIGN_STRIDE) truncated to 24 bits, set busy=1, go to DELAY (or directly to ISSUE if DELAY_CYCLES=0).
- DELAY: counts DELAY_CYCLES cycles, then enters ISSUE. icap_ce_b stays 1.
- ISSUE: exactly 14 consecutive cycles with icap_ce_b=0 and icap_we_b=0. Registered word per index:
  - 0: FFFF
  - 1: AA99
  - 2: 5566
  - 3: 3261
  - 4: addr[15:0]
  - 5: 3281
  - 6: {SPI_OPCODE, addr[23:16]}
  - 7: 32A1
  - 8: GOLDEN_ADDR[15:0]
  - 9: 32C1
  - 10: {SPI_OPCODE, GOLDEN_ADDR[23:16]}
  - 11: 30A1
  - 12: 000E
  - 13: 2000
- FINISH, the cycle after word 13:
  - icap_ce_b=1, icap_we_b=1, icap_i=FFFF
  - done=1 for one cycle, busy=0
  - then IDLE
- Latency: req to first word on icap_i is DELAY_CYCLES+1 cycles. req to done is DELAY_CYCLES+15 cycles.
- req while busy=1 is ignored. No queuing, and latched values are unchanged.
- req in the FINISH cycle is ignored. A new request is accepted from IDLE only.
- design_num changes after acceptance have no effect.
- Reset asserted mid-sequence: immediate return to reset values, icap_ce_b=1 asynchronously. A partial sequence is abandoned; the ICAP needs no abort word.
- done and err are never high together, and never high for two consecutive cycles.

Optional Feature:
- Macro: ICAP_BITSWAP_EN.
- Defined: each byte of icap_i is bit-reversed before output (bit0<->bit7 within each byte), as Spartan-6 ICAP requires. Word AA99 appears as 5599.
- Undefined: icap_i carries the raw words listed above (for simulation models and for designs with an external swap).
- Reset/idle value FFFF is the same either way.

Test Plan:
- Basic sequence. Setup: defaults, macro undefined, req with design_num=2. Required: busy at cycle+1; first word FFFF at cycle 17; word 4 = 0000 and word 6 = 0B0C (addr C0000); done at cycle 31; icap_ce_b low for exactly 14 cycles.
- Out of range. Stimulus: req with design_num=16. Required: err pulse for one cycle, busy never 1, icap_ce_b stays 1.
- Ignored request. Stimulus: req with design_num=3 mid-ISSUE of a design-1 sequence. Required: words 4/6 keep the design-1 address (0000/0B06); only one done.
- Reset abort. Stimulus: rst_b low during word 7. Required: icap_ce_b=1 and busy=0 without a clock edge. A subsequent req with design_num=0 gives a full 14-word sequence with addr 000000.
- Zero delay. Setup: DELAY_CYCLES=0, ICAP_BITSWAP_EN defined. Required: word 1 appears 2 cycles after req as 5599; word 12 appears as 0070.
- Back-to-back. Stimulus: req in the done cycle, then req the following cycle. Required: the first is ignored, the second is accepted.

Source files
------------

// File: rtl/icap_reconfig_seq.sv
// icap_reconfig_seq: drives the Spartan-6 ICAP through a multiboot IPROG
// sequence that reboots the FPGA into a selected SPI flash image.
// Optional build macro ICAP_BITSWAP_EN: bit-reverses each byte of icap_i,
// which the ICAP primitive itself expects; leave undefined for raw words.
module icap_reconfig_seq #(
    parameter logic [23:0] BASE_ADDR     = 24'h000000,
    parameter logic [23:0] DESIGN_STRIDE = 24'h060000,
    parameter int          NUM_DESIGNS   = 16,
    parameter logic [23:0] GOLDEN_ADDR   = 24'h000000,
    parameter logic [7:0]  SPI_OPCODE    = 8'h0B,
    parameter int          DELAY_CYCLES  = 16
) (
    input  logic        fastclk,
    input  logic        rst_b,
    input  logic        req,
    input  logic [4:0]  design_num,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] icap_i,
    output logic        icap_ce_b,
    output logic        icap_we_b
);

    typedef enum logic [1:0] {IDLE, DELAY, ISSUE, FINISH} state_t;

    localparam logic [31:0] DLY_LAST = (DELAY_CYCLES > 0) ? 32'(DELAY_CYCLES - 1) : 32'd0;
    localparam logic [3:0]  LAST_IDX = 4'd14;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [31:0] dly_cnt, dly_cnt_nxt;
    logic [23:0] addr, addr_nxt;
    logic [23:0] addr_calc;
    logic        in_range;
    logic        busy_nxt, done_nxt, err_nxt, ce_b_nxt, we_b_nxt;
    logic [15:0] word_nxt;

    // IPROG command word for a given position in the 14-word stream
    function automatic logic [15:0] seq_word(input logic [3:0] k, input logic [23:0] a);
        logic [15:0] w;
        case (k)
            4'd0:    w = 16'hFFFF;
            4'd1:    w = 16'hAA99;
            4'd2:    w = 16'h5566;
            4'd3:    w = 16'h3261;
            4'd4:    w = a[15:0];
            4'd5:    w = 16'h3281;
            4'd6:    w = {SPI_OPCODE, a[23:16]};
            4'd7:    w = 16'h32A1;
            4'd8:    w = GOLDEN_ADDR[15:0];
            4'd9:    w = 16'h32C1;
            4'd10:   w = {SPI_OPCODE, GOLDEN_ADDR[23:16]};
            4'd11:   w = 16'h30A1;
            4'd12:   w = 16'h000E;
            4'd13:   w = 16'h2000;
            default: w = 16'hFFFF;
        endcase
        return w;
    endfunction

    // Byte-wise bit reversal into the ICAP's bit order, when enabled
    function automatic logic [15:0] out_word(input logic [15:0] w);
        logic [15:0] r;
`ifdef ICAP_BITSWAP_EN
        for (int b = 0; b < 8; b++) begin
            r[b]     = w[7 - b];
            r[8 + b] = w[15 - b];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    // Next-state and next-output decode; outputs are all registered
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        dly_cnt_nxt = dly_cnt;
        addr_nxt    = addr;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        word_nxt    = 16'hFFFF;
        ce_b_nxt    = 1'b1;
        we_b_nxt    = 1'b1;
        addr_calc   = BASE_ADDR + 24'(design_num) * DESIGN_STRIDE;
        in_range    = (int'(design_num) < NUM_DESIGNS);

        case (state)
            IDLE: begin
                // The err cycle also swallows req so err can never repeat back-to-back
                if (req && !err) begin
                    if (!in_range) begin
                        err_nxt = 1'b1;
                    end else begin
                        addr_nxt    = addr_calc;
                        busy_nxt    = 1'b1;
                        dly_cnt_nxt = 32'd0;
                        if (DELAY_CYCLES == 0) begin
                            word_nxt  = out_word(seq_word(4'd0, addr_calc));
                            ce_b_nxt  = 1'b0;
                            we_b_nxt  = 1'b0;
                            idx_nxt   = 4'd1;
                            state_nxt = ISSUE;
                        end else begin
                            state_nxt = DELAY;
                        end
                    end
                end
            end
            DELAY: begin
                if (dly_cnt == DLY_LAST) begin
                    word_nxt    = out_word(seq_word(4'd0, addr));
                    ce_b_nxt    = 1'b0;
                    we_b_nxt    = 1'b0;
                    idx_nxt     = 4'd1;
                    dly_cnt_nxt = 32'd0;
                    state_nxt   = ISSUE;
                end else begin
                    dly_cnt_nxt = dly_cnt + 32'd1;
                end
            end
            ISSUE: begin
                if (idx == LAST_IDX) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    idx_nxt   = 4'd0;
                    state_nxt = FINISH;
                end else begin
                    word_nxt  = out_word(seq_word(idx, addr));
                    ce_b_nxt  = 1'b0;
                    we_b_nxt  = 1'b0;
                    idx_nxt   = idx + 4'd1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the ICAP deselected at once
    always_ff @(posedge fastclk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            idx       <= 4'd0;
            dly_cnt   <= 32'd0;
            addr      <= 24'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            icap_i    <= 16'hFFFF;
            icap_ce_b <= 1'b1;
            icap_we_b <= 1'b1;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            dly_cnt   <= dly_cnt_nxt;
            addr      <= addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            icap_i    <= word_nxt;
            icap_ce_b <= ce_b_nxt;
            icap_we_b <= we_b_nxt;
        end
    end

endmodule

// File: tb/tb_icap_reconfig_seq.sv
// Bench for icap_reconfig_seq: a 16-cycle-delay instance and a zero-delay
// instance share clock and reset. A cycle-indexed expectation timeline,
// filled from accepted requests, is compared every cycle; literal pins
// anchor selected cycles.
module tb_icap_reconfig_seq;

    localparam int NC = 4096;
    localparam int F_BUSY = 0, F_DONE = 1, F_ERR = 2, F_CEB = 3, F_ICAP = 4;
`ifdef ICAP_BITSWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        int          inst;
        int          field;
        logic [15:0] val;
        string       nm;
    } pin_t;

    logic        fastclk = 1'b0;
    logic        rst_b   = 1'b0;
    logic [1:0]  req_v   = 2'b00;
    logic [4:0]  dn_v [2];
    logic [1:0]  busy_v, done_v, err_v, ceb_v, web_v;
    logic [15:0] icap_v [2];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    pin_t pins[$];

    bit          e_busy [2][NC];
    bit          e_done [2][NC];
    bit          e_err  [2][NC];
    bit          e_ceb  [2][NC];
    logic [15:0] e_word [2][NC];
    int          free_at [2];

    icap_reconfig_seq #(.DELAY_CYCLES(16)) dut0 (
        .fastclk(fastclk), .rst_b(rst_b), .req(req_v[0]), .design_num(dn_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
        .icap_i(icap_v[0]), .icap_ce_b(ceb_v[0]), .icap_we_b(web_v[0])
    );

    icap_reconfig_seq #(.DELAY_CYCLES(0)) dut1 (
        .fastclk(fastclk), .rst_b(rst_b), .req(req_v[1]), .design_num(dn_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
        .icap_i(icap_v[1]), .icap_ce_b(ceb_v[1]), .icap_we_b(web_v[1])
    );

    always #5 fastclk = ~fastclk;

    always @(posedge fastclk) cyc <= cyc + 1;

    function automatic int dly(input int i);
        return (i == 0) ? 16 : 0;
    endfunction

    function automatic logic [15:0] m_out(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        if (SWAP)
            for (int b = 0; b < 16; b++) r[b] = w[(b & ~7) + (7 - (b & 7))];
        return r;
    endfunction

    function automatic logic [15:0] lit(input logic [15:0] raw, input logic [15:0] sw);
        return SWAP ? sw : raw;
    endfunction

    // Expected k-th word of the IPROG stream for flash address a (golden = 0, opcode 0B)
    function automatic logic [15:0] m_word(input int k, input logic [23:0] a);
        logic [15:0] t [14];
        t = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h0000, 16'h3281, 16'h0000,
              16'h32A1, 16'h0000, 16'h32C1, 16'h0B00, 16'h30A1, 16'h000E, 16'h2000};
        t[4] = a[15:0];
        t[6] = {8'h0B, a[23:16]};
        return m_out(t[k]);
    endfunction

    function automatic logic [15:0] act_of(input int i, input int f);
        case (f)
            F_BUSY:  return {15'd0, busy_v[i]};
            F_DONE:  return {15'd0, done_v[i]};
            F_ERR:   return {15'd0, err_v[i]};
            F_CEB:   return {15'd0, ceb_v[i]};
            default: return icap_v[i];
        endcase
    endfunction

    task automatic cmp(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = 0; i < 2; i++)
            for (int t = c; t < NC; t++) begin
                e_busy[i][t] = 1'b0;
                e_done[i][t] = 1'b0;
                e_err[i][t]  = 1'b0;
                e_ceb[i][t]  = 1'b1;
                e_word[i][t] = 16'hFFFF;
            end
    endtask

    task automatic accept(input int i, input int c, input int d);
        logic [23:0] a;
        int D;
        D = dly(i);
        a = 24'(d * 32'h60000);
        for (int t = c + 1; t <= c + D + 14; t++) if (t < NC) e_busy[i][t] = 1'b1;
        for (int k = 0; k < 14; k++)
            if (c + D + 1 + k < NC) begin
                e_word[i][c + D + 1 + k] = m_word(k, a);
                e_ceb[i][c + D + 1 + k]  = 1'b0;
            end
        if (c + D + 15 < NC) e_done[i][c + D + 15] = 1'b1;
        free_at[i] = c + D + 16;
    endtask

    // Single compare process: model update plus every comparison of the bench
    initial begin
        bit clk_evt;
        free_at[0] = 0;
        free_at[1] = 0;
        clear_from(0);
        forever begin
            @(negedge fastclk or negedge rst_b);
            #1;
            clk_evt = (fastclk == 1'b0);
            if (!rst_b) begin
                clear_from(cyc);
                free_at[0] = cyc + 1;
                free_at[1] = cyc + 1;
            end
            if (cyc < NC) begin
                for (int i = 0; i < 2; i++) begin
                    cmp("busy",   i, {15'd0, busy_v[i]}, {15'd0, e_busy[i][cyc]});
                    cmp("done",   i, {15'd0, done_v[i]}, {15'd0, e_done[i][cyc]});
                    cmp("err",    i, {15'd0, err_v[i]},  {15'd0, e_err[i][cyc]});
                    cmp("ce_b",   i, {15'd0, ceb_v[i]},  {15'd0, e_ceb[i][cyc]});
                    cmp("we_b",   i, {15'd0, web_v[i]},  {15'd0, e_ceb[i][cyc]});
                    cmp("icap_i", i, icap_v[i], e_word[i][cyc]);
                end
            end
            foreach (pins[k])
                if (pins[k].cyc == cyc)
                    cmp(pins[k].nm, pins[k].inst, act_of(pins[k].inst, pins[k].field), pins[k].val);
            if (clk_evt && rst_b) begin
                for (int i = 0; i < 2; i++)
                    if (req_v[i] && cyc >= free_at[i] && !e_err[i][cyc]) begin
                        if (int'(dn_v[i]) >= 16) begin
                            if (cyc + 1 < NC) e_err[i][cyc + 1] = 1'b1;
                        end else begin
                            accept(i, cyc, int'(dn_v[i]));
                        end
                    end
            end
        end
    end

    task automatic pin(input int c, input int i, input int f, input logic [15:0] v, input string nm);
        pin_t p;
        p.cyc = c; p.inst = i; p.field = f; p.val = v; p.nm = nm;
        pins.push_back(p);
    endtask

    task automatic tick();
        @(posedge fastclk);
        #1;
    endtask

    task automatic idle(input int n);
        req_v = 2'b00;
        repeat (n) tick();
    endtask

    initial begin
        int c;
        dn_v[0] = 5'd0;
        dn_v[1] = 5'd0;
        pin(1, 0, F_BUSY, 16'h0000, "rst_busy");
        pin(1, 0, F_ICAP, 16'hFFFF, "rst_icap");
        pin(1, 0, F_CEB,  16'h0001, "rst_ce_b");
        pin(1, 1, F_DONE, 16'h0000, "rst_done");
        repeat (3) tick();
        rst_b = 1'b1;
        idle(3);

        // basic sequence, design 2 -> addr C0000
        tick(); c = cyc; req_v[0] = 1'b1; dn_v[0] = 5'd2;
        pin(c + 1,  0, F_BUSY, 16'h0001, "basic_busy");
        pin(c + 16, 0, F_CEB,  16'h0001, "basic_ce_pre");
        pin(c + 17, 0, F_CEB,  16'h0000, "basic_ce_first");
        pin(c + 17, 0, F_ICAP, 16'hFFFF, "basic_w0");
        pin(c + 21, 0, F_ICAP, 16'h0000, "basic_w4");
        pin(c + 23, 0, F_ICAP, lit(16'h0B0C, 16'hD030), "basic_w6");
        pin(c + 30, 0, F_CEB,  16'h0000, "basic_ce_last");
        pin(c + 31, 0, F_CEB,  16'h0001, "basic_ce_post");
        pin(c + 31, 0, F_DONE, 16'h0001, "basic_done");
        pin(c + 31, 0, F_BUSY, 16'h0000, "basic_busy_end");
        tick(); req_v[0] = 1'b0; dn_v[0] = 5'd9;
        idle(40);

        // out-of-range design
        tick(); c = cyc; req_v[0] = 1'b1; dn_v[0] = 5'd16;
        pin(c + 1, 0, F_ERR,  16'h0001, "oor_err");
        pin(c + 1, 0, F_BUSY, 16'h0000, "oor_busy");
        pin(c + 2, 0, F_ERR,  16'h0000, "oor_err_once");
        pin(c + 3, 0, F_CEB,  16'h0001, "oor_ce_b");
        tick(); req_v[0] = 1'b0;
        idle(5);

        // request during ISSUE ignored
        tick(); c = cyc; req_v[0] = 1'b1; dn_v[0] = 5'd1;
        tick(); req_v[0] = 1'b0;
        repeat (19) tick();
        req_v[0] = 1'b1; dn_v[0] = 5'd3;
        pin(c + 21, 0, F_ICAP, 16'h0000, "ign_w4");
        pin(c + 23, 0, F_ICAP, lit(16'h0B06, 16'hD060), "ign_w6");
        pin(c + 31, 0, F_DONE, 16'h0001, "ign_done");
        pin(c + 37, 0, F_BUSY, 16'h0000, "ign_no_busy");
        pin(c + 51, 0, F_DONE, 16'h0000, "ign_no_done2");
        tick(); req_v[0] = 1'b0;
        idle(40);

        // reset during word 7
        tick(); c = cyc; req_v[0] = 1'b1; dn_v[0] = 5'd1;
        tick(); req_v[0] = 1'b0;
        repeat (23) tick();
        pin(c + 23, 0, F_CEB,  16'h0000, "abort_mid_ce");
        pin(c + 24, 0, F_CEB,  16'h0001, "abort_ce_b");
        pin(c + 24, 0, F_BUSY, 16'h0000, "abort_busy");
        pin(c + 24, 0, F_ICAP, 16'hFFFF, "abort_icap");
        #2 rst_b = 1'b0;
        tick();
        tick(); rst_b = 1'b1;
        tick(); c = cyc; req_v[0] = 1'b1; dn_v[0] = 5'd0;
        pin(c + 17, 0, F_ICAP, 16'hFFFF, "re_w0");
        pin(c + 21, 0, F_ICAP, 16'h0000, "re_w4");
        pin(c + 23, 0, F_ICAP, lit(16'h0B00, 16'hD000), "re_w6");
        pin(c + 30, 0, F_ICAP, lit(16'h2000, 16'h0400), "re_w13");
        pin(c + 31, 0, F_DONE, 16'h0001, "re_done");
        tick(); req_v[0] = 1'b0;
        idle(40);

        // zero-delay instance
        tick(); c = cyc; req_v[1] = 1'b1; dn_v[1] = 5'd2;
        pin(c + 1,  1, F_CEB,  16'h0000, "zd_ce_b");
        pin(c + 1,  1, F_ICAP, 16'hFFFF, "zd_w0");
        pin(c + 2,  1, F_ICAP, lit(16'hAA99, 16'h5599), "zd_w1");
        pin(c + 13, 1, F_ICAP, lit(16'h000E, 16'h0070), "zd_w12");
        pin(c + 14, 1, F_BUSY, 16'h0001, "zd_busy");
        pin(c + 15, 1, F_DONE, 16'h0001, "zd_done");
        pin(c + 15, 1, F_BUSY, 16'h0000, "zd_busy_end");
        tick(); req_v[1] = 1'b0;
        idle(20);

        // back-to-back: req in done cycle ignored, next cycle accepted
        tick(); c = cyc; req_v[0] = 1'b1; dn_v[0] = 5'd5;
        tick(); req_v[0] = 1'b0;
        repeat (30) tick();
        req_v[0] = 1'b1; dn_v[0] = 5'd7;
        tick(); dn_v[0] = 5'd4;
        tick(); req_v[0] = 1'b0;
        pin(c + 31, 0, F_DONE, 16'h0001, "b2b_done1");
        pin(c + 32, 0, F_BUSY, 16'h0000, "b2b_ignored");
        pin(c + 33, 0, F_BUSY, 16'h0001, "b2b_accepted");
        pin(c + 53, 0, F_ICAP, 16'h0000, "b2b_w4");
        pin(c + 55, 0, F_ICAP, lit(16'h0B18, 16'hD018), "b2b_w6");
        pin(c + 63, 0, F_DONE, 16'h0001, "b2b_done2");
        idle(40);

        // randomized requests on both instances
        for (int n = 0; n < 1500; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                req_v[i] = ($urandom_range(0, 7) == 0);
                dn_v[i]  = 5'($urandom_range(0, 19));
            end
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
